rr_arb8: RTL and testbench

- Round-robin arbiter that drives the 3-bit select `s` of the 8:1 data mux and its valid/ready handshake.
- Sits directly upstream of the mux: eight requesters raise `req`; the arbiter picks one and presents its index on `sel` (wired to mux `s`).
- Downstream sees a single valid/ready stream.
- Pure control path; no data storage.

---
 rtl/rr_arb8.sv | 123 ++++++++++++
 tb/tb_rr_arb8.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter driving the select, valid and ready of an 8:1 data mux.
// Latency: a request seen in IDLE is granted one edge later; back-to-back grants when another requester waits.
// Backpressure: the grant is held while out_ready=0; in_ready is gnt qualified by out_ready.
// Optional build macro RR_ARB8_LOCK_EN: when defined, the grant stays with one requester until its beat with last=1.
module rr_arb8 #(
  parameter logic [2:0] ptr_init = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       last,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       out_valid,
  output logic [7:0] in_ready,
  output logic       xfer
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] r_state;
  logic [2:0] r_sel;
  logic [2:0] r_ptr;
  logic [7:0] r_gnt;

  logic [0:0] w_state_nx;
  logic [2:0] w_sel_nx;
  logic [2:0] w_ptr_nx;
  logic [7:0] w_gnt_nx;
  logic [7:0] w_mask;
  logic [2:0] w_pick_idle;
  logic [2:0] w_pick_next;
  logic       w_last_beat;

  // First set bit of r at or after start, wrapping 7->0. Scanning the
  // offsets from far to near lets the nearest hit overwrite the others.
  function automatic logic [2:0] f_arb(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    f_arb = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) f_arb = idx;
    end
  endfunction

`ifdef RR_ARB8_LOCK_EN
  // Only the closing beat of a packet releases the grant.
  assign w_last_beat = last;
`else
  // Every beat releases the grant; last is accepted but has no effect.
  logic w_unused_last;
  assign w_unused_last = last;
  assign w_last_beat   = 1'b1;
`endif

  // The current winner is masked out because its req this cycle is stale
  // (it is being consumed by the transfer).
  assign w_mask      = req & ~r_gnt;
  assign w_pick_idle = f_arb(req, r_ptr + 3'd1);
  assign w_pick_next = f_arb(w_mask, r_sel + 3'd1);

  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out_valid = (r_state == ST_GRANT) & req[r_sel];
  assign xfer      = out_valid & out_ready;
  assign in_ready  = r_gnt & {8{out_ready}};

  // Next-state selection: start a grant from IDLE, then hold, re-arbitrate or release in GRANT.
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_ptr_nx   = r_ptr;
    w_gnt_nx   = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nx = ST_GRANT;
          w_sel_nx   = w_pick_idle;
          w_gnt_nx   = 8'd1 << w_pick_idle;
        end
      end
      ST_GRANT: begin
        if (!req[r_sel]) begin
          // Requester withdrew: drop the grant but keep the pointer so it
          // is first in line again.
          w_state_nx = ST_IDLE;
          w_gnt_nx   = 8'd0;
        end else if (out_ready && w_last_beat) begin
          w_ptr_nx = r_sel;
          if (|w_mask) begin
            w_sel_nx = w_pick_next;
            w_gnt_nx = 8'd1 << w_pick_next;
          end else begin
            w_state_nx = ST_IDLE;
            w_gnt_nx   = 8'd0;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_gnt_nx   = 8'd0;
      end
    endcase
  end

  // State, grant and pointer registers; reset clears outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
      r_gnt   <= 8'd0;
      r_ptr   <= ptr_init;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_gnt   <= w_gnt_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

endmodule

// File: tb/tb_rr_arb8.sv
// Testbench for rr_arb8: directed scenarios followed by random traffic,
// every cycle compared against a behavioural round-robin model.
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       last;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out_valid;
  logic [7:0] in_ready;
  logic       xfer;

  int n_pass;
  int n_fail;
  int n_total;

  // Reference model: is a requester currently granted, which one, and who was served last.
  bit m_busy;
  int m_sel;
  int m_ptr;

  logic [2:0] obs_sel;
  logic       obs_ov;
  logic [7:0] obs_gnt;
  logic [7:0] rnd_req;

  int exp_seq[4];
  logic lst_seq[4];

  rr_arb8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .xfer      (xfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_req(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 7;
  endtask

  task automatic check_outputs();
    logic [7:0] eg;
    logic       eov;
    eg  = m_busy ? (8'd1 << m_sel) : 8'd0;
    eov = m_busy && req[m_sel];
    chk("sel",       32'(sel),       32'(m_sel));
    chk("gnt",       32'(gnt),       32'(eg));
    chk("out_valid", 32'(out_valid), 32'(eov));
    chk("in_ready",  32'(in_ready),  32'(eg & {8{out_ready}}));
    chk("xfer",      32'(xfer),      32'(eov & out_ready));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit         lastbeat;
    logic [7:0] rest;
`ifdef RR_ARB8_LOCK_EN
    lastbeat = last;
`else
    lastbeat = 1'b1;
`endif
    if (!m_busy) begin
      if (req != 8'd0) begin
        m_sel  = first_req(req, (m_ptr + 1) % 8);
        m_busy = 1'b1;
      end
    end else if (!req[m_sel]) begin
      m_busy = 1'b0;
    end else if (out_ready && lastbeat) begin
      m_ptr = m_sel;
      rest  = req;
      rest[m_sel] = 1'b0;
      if (rest != 8'd0) m_sel = first_req(rest, (m_sel + 1) % 8);
      else              m_busy = 1'b0;
    end
  endtask

  // One clock: apply inputs at the falling edge, check, advance, return at the next falling edge.
  task automatic cyc(input logic [7:0] r, input logic rdy, input logic l);
    req       = r;
    out_ready = rdy;
    last      = l;
    #1;
    obs_sel = sel;
    obs_ov  = out_valid;
    obs_gnt = gnt;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req       = 8'd0;
    out_ready = 1'b0;
    last      = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst_n = 1'b0; req = 8'd0; last = 1'b0; out_ready = 1'b0;
    model_reset();

    // Reset values
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests
    repeat (5) cyc(8'h00, 1'b1, 1'b0);

    // All requesting: order 0..7,0 with a transfer every cycle
    cyc(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 1'b1, 1'b0);
      chk("ff_order", 32'(obs_sel), 32'(i % 8));
      chk("ff_valid", 32'(obs_ov), 32'd1);
    end

    // Sole requester 4: bubble after every beat, then a stall
    do_reset();
    cyc(8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h10, 1'b1, 1'b0);
      chk("solo_valid", 32'(obs_ov), 32'((i % 2) == 0));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(8'h10, 1'b0, 1'b0);
      chk("stall_sel", 32'(obs_sel), 32'd4);
      chk("stall_valid", 32'(obs_ov), 32'd1);
    end
    cyc(8'h10, 1'b1, 1'b0);

    // Withdrawal keeps the pointer, so 2 wins again
    do_reset();
    cyc(8'h04, 1'b0, 1'b0);
    cyc(8'h04, 1'b0, 1'b0);
    chk("wd_sel", 32'(obs_sel), 32'd2);
    cyc(8'h00, 1'b0, 1'b0);
    chk("wd_valid", 32'(obs_ov), 32'd0);
    cyc(8'h0C, 1'b1, 1'b0);
    cyc(8'h0C, 1'b1, 1'b0);
    chk("wd_regrant", 32'(obs_sel), 32'd2);

    // Asynchronous reset between clock edges while granted to 5
    do_reset();
    cyc(8'h20, 1'b0, 1'b0);
    cyc(8'h20, 1'b0, 1'b0);
    chk("pre_rst_gnt", 32'(obs_gnt), 32'h20);
    req = 8'h20; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt",  32'(gnt),       32'd0);
    chk("arst_sel",  32'(sel),       32'd0);
    chk("arst_xfer", 32'(xfer),      32'd0);
    chk("arst_ov",   32'(out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8'h21, 1'b1, 1'b0);
    cyc(8'h21, 1'b1, 1'b0);
    chk("post_rst_sel", 32'(obs_sel), 32'd0);

    // Packet lock: requester 1 sends three beats, last on the third
    do_reset();
    lst_seq = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef RR_ARB8_LOCK_EN
    exp_seq = '{1, 1, 1, 2};
`else
    exp_seq = '{1, 2, 1, 2};
`endif
    cyc(8'h06, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h06, 1'b1, lst_seq[i]);
      chk("lock_seq", 32'(obs_sel), 32'(exp_seq[i]));
    end

    // Random traffic against the model
    do_reset();
    rnd_req = 8'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = 8'($urandom);
      cyc(rnd_req, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
